// File: rtl/asic_arb_pkg.sv
// Shared types and helpers for the memory request arbiter: FSM states,
// requester IDs and the ID-width helper.
package asic_arb_pkg;

    localparam int ADDR_W = 40;
    localparam int CMD_W  = 5;
    localparam int TYP_W  = 3;

    localparam int REQ_X = 0;
    localparam int REQ_W = 1;
    localparam int REQ_R = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding memory requests; the head is
// read combinationally so responses can be routed in the cycle they arrive.
module arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int IDW   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [IDW-1:0]           push_id,
    input  logic                     pop,
    output logic [IDW-1:0]           head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);

    logic [IDW-1:0] mem [DEPTH];
    logic [PW-1:0]  wr_ptr_reg;
    logic [PW-1:0]  rd_ptr_reg;
    logic [PW:0]    count_reg;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_id;
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign full  = (count_reg == (PW+1)'(DEPTH));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one memory request/response port between NREQ requesters.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module mem_req_arbiter
    import asic_arb_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid_i,
    output logic [NREQ-1:0]        req_ready_o,
    input  logic [NREQ*ADDR_W-1:0] req_addr_i,
    input  logic [NREQ*CMD_W-1:0]  req_cmd_i,
    input  logic [NREQ*TYP_W-1:0]  req_typ_i,
    input  logic [NREQ*XLEN-1:0]   req_data_i,
    output logic [NREQ-1:0]        resp_valid_o,
    output logic [XLEN-1:0]        resp_data_o,
    input  logic                   mem_req_ready_i,
    output logic                   mem_req_valid_o,
    output logic [ADDR_W-1:0]      mem_req_addr_o,
    output logic [CMD_W-1:0]       mem_req_cmd_o,
    output logic [TYP_W-1:0]       mem_req_typ_o,
    output logic [XLEN-1:0]        mem_req_data_o,
    input  logic                   mem_resp_valid_i,
    input  logic [XLEN-1:0]        mem_resp_data_i,
    output logic                   busy_o,
    output logic                   spurious_o
);
    localparam int IDW = id_width(NREQ);
    localparam int CW  = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] addr_arr [NREQ];
    logic [CMD_W-1:0]  cmd_arr  [NREQ];
    logic [TYP_W-1:0]  typ_arr  [NREQ];
    logic [XLEN-1:0]   data_arr [NREQ];

    logic [IDW-1:0]    winner;
    logic [ADDR_W-1:0] win_addr;
    logic [CMD_W-1:0]  win_cmd;
    logic [TYP_W-1:0]  win_typ;
    logic [XLEN-1:0]   win_data;

    logic              accept, push, pop, issue_next;
    logic [IDW-1:0]    fifo_head;
    logic [CW-1:0]     fifo_count, count_next;
    logic              fifo_full, fifo_empty;

    logic              issue_valid_reg;
    logic [ADDR_W-1:0] issue_addr_reg;
    logic [CMD_W-1:0]  issue_cmd_reg;
    logic [TYP_W-1:0]  issue_typ_reg;
    logic [XLEN-1:0]   issue_data_reg;
    arb_state_t        state_reg;
    logic              spurious_reg;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign addr_arr[gi]     = req_addr_i[ADDR_W*gi +: ADDR_W];
            assign cmd_arr[gi]      = req_cmd_i[CMD_W*gi +: CMD_W];
            assign typ_arr[gi]      = req_typ_i[TYP_W*gi +: TYP_W];
            assign data_arr[gi]     = req_data_i[XLEN*gi +: XLEN];
            assign req_ready_o[gi]  = push && (winner == IDW'(gi));
            assign resp_valid_o[gi] = pop && (fifo_head == IDW'(gi));
        end
    endgenerate

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] last_grant_reg;
    logic [IDW-1:0] idx_w;
    logic           found;

    // Search starts one past the last grant and wraps modulo NREQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx_w  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_w = IDW'((int'(last_grant_reg) + k) % NREQ);
            if (!found && req_valid_i[idx_w]) begin
                winner = idx_w;
                found  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid_i[k]) winner = IDW'(k);
        end
    end
`endif

    always_comb begin
        win_addr = '0;
        win_cmd  = '0;
        win_typ  = '0;
        win_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (winner == IDW'(k)) begin
                win_addr = addr_arr[k];
                win_cmd  = cmd_arr[k];
                win_typ  = typ_arr[k];
                win_data = data_arr[k];
            end
        end
    end

    // A same-cycle response pop deliberately does not open a slot for a push.
    assign accept     = reset && !fifo_full && (!issue_valid_reg || mem_req_ready_i);
    assign push       = accept && (|req_valid_i);
    assign pop        = mem_resp_valid_i && !fifo_empty;
    assign issue_next = push || (issue_valid_reg && !mem_req_ready_i);
    assign count_next = fifo_count + CW'(push) - CW'(pop);

    arb_id_fifo #(.DEPTH(DEPTH), .IDW(IDW)) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .push_id (winner),
        .pop     (pop),
        .head    (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_valid_reg <= 1'b0;
            issue_addr_reg  <= '0;
            issue_cmd_reg   <= '0;
            issue_typ_reg   <= '0;
            issue_data_reg  <= '0;
            state_reg       <= ARB_IDLE;
            spurious_reg    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_reg  <= IDW'(NREQ - 1);
`endif
        end else begin
            if (push) begin
                issue_valid_reg <= 1'b1;
                issue_addr_reg  <= win_addr;
                issue_cmd_reg   <= win_cmd;
                issue_typ_reg   <= win_typ;
                issue_data_reg  <= win_data;
            end else if (mem_req_ready_i) begin
                issue_valid_reg <= 1'b0;
            end
            state_reg <= issue_next ? ARB_ISSUE :
                         (count_next != '0) ? ARB_WAIT : ARB_IDLE;
            if (mem_resp_valid_i && fifo_empty) spurious_reg <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            if (push) last_grant_reg <= winner;
`endif
        end
    end

    assign mem_req_valid_o = issue_valid_reg;
    assign mem_req_addr_o  = issue_addr_reg;
    assign mem_req_cmd_o   = issue_cmd_reg;
    assign mem_req_typ_o   = issue_typ_reg;
    assign mem_req_data_o  = issue_data_reg;
    assign resp_data_o     = mem_resp_data_i;
    assign busy_o          = (state_reg != ARB_IDLE);
    assign spurious_o      = spurious_reg;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized scoreboard bench for mem_req_arbiter against a queue-based model
// of arbitration, issue-stage occupancy and in-order response ownership.
`timescale 1ns/1ps
module tb_mem_req_arbiter;
    import asic_arb_pkg::*;

    localparam int NREQ  = 3;
    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req_valid_i;
    logic [NREQ-1:0]        req_ready_o;
    logic [NREQ*ADDR_W-1:0] req_addr_i;
    logic [NREQ*CMD_W-1:0]  req_cmd_i;
    logic [NREQ*TYP_W-1:0]  req_typ_i;
    logic [NREQ*XLEN-1:0]   req_data_i;
    logic [NREQ-1:0]        resp_valid_o;
    logic [XLEN-1:0]        resp_data_o;
    logic                   mem_req_ready_i;
    logic                   mem_req_valid_o;
    logic [ADDR_W-1:0]      mem_req_addr_o;
    logic [CMD_W-1:0]       mem_req_cmd_o;
    logic [TYP_W-1:0]       mem_req_typ_o;
    logic [XLEN-1:0]        mem_req_data_o;
    logic                   mem_resp_valid_i;
    logic [XLEN-1:0]        mem_resp_data_i;
    logic                   busy_o;
    logic                   spurious_o;

    always #5 clk = ~clk;

    mem_req_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_addr_i       (req_addr_i),
        .req_cmd_i        (req_cmd_i),
        .req_typ_i        (req_typ_i),
        .req_data_i       (req_data_i),
        .resp_valid_o     (resp_valid_o),
        .resp_data_o      (resp_data_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_cmd_o    (mem_req_cmd_o),
        .mem_req_typ_o    (mem_req_typ_o),
        .mem_req_data_o   (mem_req_data_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .busy_o           (busy_o),
        .spurious_o       (spurious_o)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [CMD_W-1:0]  cmd;
        logic [TYP_W-1:0]  typ;
        logic [XLEN-1:0]   data;
    } req_t;

    req_t exp_issue_q[$];
    int   exp_id_q[$];
    bit   m_stage = 1'b0;
    int   m_last  = NREQ - 1;
    bit   m_spur  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int issued_cnt   = 0;
    int returned_cnt = 0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic int model_winner(input logic [NREQ-1:0] v, input int last);
        int start;
        start = last + 1;
`ifndef ARB_ROUND_ROBIN_EN
        start = 0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (v[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    // Monitor/scoreboard: samples mid-cycle, after the driver has settled inputs.
    always @(negedge clk) begin : monitor
        int w;
        bit acc;
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] exp_resp;
        req_t r;
        #2;
        if (!reset) begin
            chk("rst_req_ready", req_ready_o, '0);
            chk("rst_mem_req_valid", mem_req_valid_o, 1'b0);
            chk("rst_mem_req_fields", {mem_req_addr_o, mem_req_cmd_o, mem_req_typ_o, mem_req_data_o}, '0);
            chk("rst_resp_valid", resp_valid_o, '0);
            chk("rst_busy", busy_o, 1'b0);
            chk("rst_spurious", spurious_o, 1'b0);
            exp_issue_q.delete();
            exp_id_q.delete();
            m_stage = 1'b0;
            m_last  = NREQ - 1;
            m_spur  = 1'b0;
        end else begin
            chk("mem_req_valid", mem_req_valid_o, m_stage);
            chk("busy", busy_o, m_stage || (exp_id_q.size() > 0));
            chk("spurious", spurious_o, m_spur);
            if (m_stage && exp_issue_q.size() > 0) begin
                r = exp_issue_q[0];
                chk("issue_fields", {mem_req_addr_o, mem_req_cmd_o, mem_req_typ_o, mem_req_data_o}, r);
            end

            acc = (exp_id_q.size() < DEPTH) && (!m_stage || mem_req_ready_i);
            w = acc ? model_winner(req_valid_i, m_last) : -1;
            exp_rdy = (w >= 0) ? NREQ'(1) << w : '0;
            chk("req_ready", req_ready_o, exp_rdy);

            exp_resp = '0;
            if (mem_resp_valid_i) begin
                if (exp_id_q.size() > 0) begin
                    exp_resp = NREQ'(1) << exp_id_q[0];
                    chk("resp_data", resp_data_o, mem_resp_data_i);
                    $display("resp  id=%0d data=%h", exp_id_q[0], mem_resp_data_i);
                    void'(exp_id_q.pop_front());
                end else begin
                    $display("resp  spurious data=%h", mem_resp_data_i);
                    m_spur = 1'b1;
                end
            end
            chk("resp_valid", resp_valid_o, exp_resp);

            if (m_stage && mem_req_ready_i) begin
                r = exp_issue_q.pop_front();
                issued_cnt++;
                $display("issue addr=%h cmd=%0d typ=%0d data=%h", r.addr, r.cmd, r.typ, r.data);
                m_stage = 1'b0;
            end
            if (w >= 0) begin
                r.addr = req_addr_i[ADDR_W*w +: ADDR_W];
                r.cmd  = req_cmd_i[CMD_W*w +: CMD_W];
                r.typ  = req_typ_i[TYP_W*w +: TYP_W];
                r.data = req_data_i[XLEN*w +: XLEN];
                exp_issue_q.push_back(r);
                exp_id_q.push_back(w);
                m_stage = 1'b1;
                m_last  = w;
            end
        end
    end

    // One clock of stimulus; the memory side returns a response with probability resp_pct.
    task automatic cycle(input logic [NREQ-1:0] v, input logic rdy, input int resp_pct);
        @(negedge clk);
        req_valid_i = v;
        for (int i = 0; i < NREQ; i++) begin
            req_addr_i[ADDR_W*i +: ADDR_W] = {$urandom, $urandom};
            req_cmd_i[CMD_W*i +: CMD_W]    = CMD_W'($urandom_range(0, 1));
            req_typ_i[TYP_W*i +: TYP_W]    = TYP_W'($urandom_range(0, 3));
            req_data_i[XLEN*i +: XLEN]     = {$urandom, $urandom};
        end
        mem_req_ready_i  = rdy;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = {$urandom, $urandom};
        if (issued_cnt > returned_cnt && int'($urandom_range(0, 99)) < resp_pct) begin
            mem_resp_valid_i = 1'b1;
            returned_cnt++;
        end
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        reset = 1'b0;
        req_valid_i = '0;
        mem_resp_valid_i = 1'b0;
        mem_req_ready_i = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drain();
        repeat (20) cycle('0, 1'b1, 100);
    endtask

    initial begin
        reset = 1'b0;
        req_valid_i = '0;
        req_addr_i = '0;
        req_cmd_i = '0;
        req_typ_i = '0;
        req_data_i = '0;
        mem_req_ready_i = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Single load from the W loader, answered with 0x5A.
        cycle(3'b010, 1'b1, 0);
        req_addr_i[ADDR_W*REQ_W +: ADDR_W] = 40'h10_00;
        req_cmd_i[CMD_W*REQ_W +: CMD_W] = '0;
        cycle('0, 1'b1, 0);
        cycle('0, 1'b1, 100);
        mem_resp_data_i = 64'h5A;
        drain();

        // Every requester asserting every cycle.
        repeat (12) cycle(3'b111, 1'b1, 100);
        drain();

        // Fill the FIFO with no responses, then release one slot.
        repeat (6) cycle(3'b111, 1'b1, 0);
        cycle(3'b111, 1'b1, 100);
        cycle(3'b111, 1'b1, 0);
        cycle('0, 1'b1, 0);
        drain();

        // Hold the issue stage with the memory not ready.
        cycle(3'b100, 1'b1, 0);
        repeat (5) cycle(3'b011, 1'b0, 0);
        cycle('0, 1'b1, 0);
        drain();

        // Random traffic.
        repeat (1500) cycle(NREQ'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, 60);
        drain();

        // Response while idle is dropped and flagged.
        cycle('0, 1'b1, 0);
        mem_resp_valid_i = 1'b1;
        repeat (4) cycle('0, 1'b1, 0);

        // Reset with two requests outstanding; their late responses are spurious.
        apply_reset(2);
        cycle(3'b001, 1'b1, 0);
        cycle(3'b010, 1'b1, 0);
        cycle('0, 1'b1, 0);
        cycle('0, 1'b1, 0);
        apply_reset(2);
        repeat (4) cycle('0, 1'b1, 100);
        repeat (2) cycle('0, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
